wait_mem: RTL and testbench
===========================

WAIT_MEM -- requirements
Module: wait_mem

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 256: number of words; SHALL be a power of two.
REQ-003 Parameter LATENCY, default 2: cycles from request acceptance to response; SHALL be at least 1.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 req_valid  input  1  requester has a valid request.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_be  input  DATA_W/8  byte enables for writes; bit i SHALL enable bits [8i+7:8i].
REQ-012 rsp_valid  output  1  response is present.
REQ-013 rsp_ready  input  1  requester accepts the response.
REQ-014 rsp_rdata  output  DATA_W  read data.
REQ-015 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-016 Define BPW = DATA_W/8 and OFS = log2(BPW); word index = req_addr[OFS+log2(DEPTH)-1:OFS].
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_* SHALL be sampled on that edge only.
REQ-018 FSM states: IDLE, WAIT, RESP.
- req_ready SHALL be 1 only in IDLE (Moore output).
- rsp_valid SHALL be 1 only in RESP.
REQ-019 IDLE to WAIT on acceptance when LATENCY>1, loading the counter with LATENCY-1; IDLE to RESP directly on acceptance when LATENCY=1.
REQ-020 WAIT: decrement the counter every cycle; go to RESP on the edge where the counter equals 1. rsp_valid SHALL first be high exactly LATENCY cycles after the acceptance edge.
REQ-021 RESP to IDLE on an edge with rsp_ready=1. At most one request SHALL be outstanding; minimum request period is LATENCY+1 cycles.
REQ-022 Error condition: req_addr[OFS-1:0] != 0 (misaligned), or req_addr >= DEPTH*BPW (out of range). rsp_err=1 on error, else 0.
REQ-023 Error requests SHALL still follow the full LATENCY/handshake timing; memory SHALL NOT be modified.
REQ-024 Valid writes SHALL update the enabled bytes on the acceptance edge; disabled bytes SHALL keep their value; req_be=0 is a legal no-op write with rsp_err=0.
REQ-025 Valid reads SHALL capture the word on the acceptance edge into a holding register.
REQ-026 rsp_rdata SHALL be 0 for writes and for errors.
REQ-027 rsp_rdata and rsp_err SHALL be stable for the whole RESP state, including any backpressure (rsp_ready=0).
REQ-028 req_valid while not in IDLE SHALL be ignored; the block SHALL NOT queue it.

Reset
REQ-029 When rst=0 at a rising edge:
- state SHALL become IDLE and the counter 0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 from the first cycle after release.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 Reset during WAIT or RESP SHALL drop the pending response. A write accepted before reset SHALL remain committed.
REQ-032 rst=0 coincident with req_valid=1 SHALL NOT accept the request.

Structure
REQ-033 Shared package mem_pkg SHALL hold:
- the FSM state enum (IDLE, WAIT, RESP);
- a log2 helper function;
- default DATA_W, DEPTH and LATENCY constants.
REQ-034 The storage SHALL be a sub-module mem_array: single port, synchronous byte-enabled write, with a read port registered by the wait_mem holding register.
REQ-035 The FSM, latency counter, error decode and response registers SHALL reside in wait_mem.

Verification (DATA_W=32, DEPTH=256, LATENCY=3)
REQ-036 Write 0xDEADBEEF to 0x10 with be=1111, then read 0x10 -> rsp_valid rises 3 cycles after each acceptance; read rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Write 0x000000AA to 0x10 with be=0001, then read 0x10 -> rsp_rdata=0xDEADBEAA.
REQ-038 Write to 0x11 (misaligned) and read 0x400 (out of range) -> rsp_err=1 and rsp_rdata=0 for both; a following read of 0x10 still returns 0xDEADBEAA.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; after the handshake edge, req_ready=1 in the next cycle.
REQ-040 Assert rst=0 one cycle after accepting a read -> rsp_valid never rises for it; req_ready=1 in the cycle after release; a new read returns correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state, log2 helper and default sizing for wait_mem
package mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF = 256;
   localparam int LATENCY_DEF = 2;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word storage with byte-enabled synchronous write and combinational read
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   addr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [DATA_W/8-1:0]       be,
   output logic [DATA_W-1:0]         rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   assign rdata = mem[addr];
   always_ff @(posedge clk)
      if (we)
         for (int b = 0; b < DATA_W/8; b++)
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: rtl/wait_mem.sv
// wait_mem: fixed-latency memory, one request outstanding, with alignment/range error decode
module wait_mem
   import mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int LATENCY = LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);
   localparam int BPW = DATA_W / 8;
   localparam int OFS = clog2(BPW);
   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(LATENCY) > 0 ? clog2(LATENCY) : 1;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] mem_rdata, rdata_q;
   logic err_q, err, accept;
   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign accept = req_valid && req_ready;
   assign err = |(req_addr & 32'(BPW - 1)) || 64'(req_addr) >= 64'(DEPTH) * 64'(BPW);
   assign rsp_rdata = rdata_q;
   assign rsp_err = err_q;
   // rst gates the write so a request coincident with reset never commits
   mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .we    (accept && rst && req_we && !err),
      .addr  (req_addr[OFS+AW-1:OFS]),
      .wdata (req_wdata),
      .be    (req_be),
      .rdata (mem_rdata)
   );
   always_comb
      state_n = state == IDLE ? (req_valid ? (LATENCY > 1 ? WAIT : RESP) : IDLE) :
                state == WAIT ? (cnt == CW'(1) ? RESP : WAIT) :
                (rsp_ready ? IDLE : RESP);
   always_ff @(posedge clk)
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         rdata_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            cnt <= CW'(LATENCY - 1);
            rdata_q <= (err || req_we) ? '0 : mem_rdata;
            err_q <= err;
         end else if (state == WAIT) cnt <= cnt - CW'(1);
      end
endmodule

// File: tb/tb_wait_mem.sv
// tb_wait_mem: directed and randomized checks of wait_mem against a cycle-count reference model
module tb_wait_mem;
   localparam int LAT = 3;
   logic clk = 0, rst = 0, req_valid = 0, req_we = 0, rsp_ready = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic [3:0] req_be = 0;
   logic req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   int tests = 0, fails = 0;
   logic [31:0] mw [0:255];
   bit busy = 0, live = 0, m_err = 0;
   int cyc = 0, due = 0;
   logic [31:0] m_rd = 0;

   wait_mem #(.DATA_W(32), .DEPTH(256), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: a response is due LAT-1 edges after the acceptance edge and leaves on a ready edge
   initial begin
      bit v;
      forever begin
         @(posedge clk);
         v = busy && cyc >= due;
         if (!rst) begin
            busy = 0;
            live = 1;
         end else if (!busy) begin
            if (req_valid) begin
               busy = 1;
               due = cyc + LAT;
               m_err = (req_addr % 4 != 0) || (req_addr >= 1024);
               m_rd = (m_err || req_we) ? 32'h0 : mw[req_addr / 4];
               if (!m_err && req_we)
                  for (int b = 0; b < 4; b++)
                     if (req_be[b]) mw[req_addr / 4][8*b +: 8] = req_wdata[8*b +: 8];
            end
         end else if (v && rsp_ready) busy = 0;
         cyc++;
      end
   end

   initial begin
      bit ev;
      forever begin
         @(negedge clk);
         if (live) begin
            ev = busy && cyc >= due;
            check("req_ready", 32'(req_ready), 32'(!busy));
            check("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
               check("rsp_rdata", rsp_rdata, m_rd);
               check("rsp_err", 32'(rsp_err), 32'(m_err));
            end
         end
      end
   end

   task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input int hold, output logic [31:0] rd, output logic er, output int lat);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_be = be; rsp_ready = 0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      lat = 1;
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
      rd = rsp_rdata;
      er = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_rdata", rsp_rdata, m_rd);
         check("hold_err", 32'(rsp_err), 32'(m_err));
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check("ready_after_rsp", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] rd, a;
      logic er;
      int lat, r;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1;
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      for (int w = 0; w < 16; w++) xact(1, 32'(w * 4), $urandom, 4'hF, 0, rd, er, lat);
      xact(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
      check("wr_latency", 32'(lat), 32'd3);
      check("wr_rdata", rd, 32'h0);
      check("wr_err", 32'(er), 32'd0);
      xact(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      check("rd_latency", 32'(lat), 32'd3);
      check("rd_rdata", rd, 32'hDEADBEEF);
      check("rd_err", 32'(er), 32'd0);
      xact(1, 32'h10, 32'h000000AA, 4'h1, 0, rd, er, lat);
      xact(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      check("be_rdata", rd, 32'hDEADBEAA);
      xact(1, 32'h11, 32'h12345678, 4'hF, 0, rd, er, lat);
      check("misalign_err", 32'(er), 32'd1);
      check("misalign_rdata", rd, 32'h0);
      check("misalign_latency", 32'(lat), 32'd3);
      xact(0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat);
      check("range_err", 32'(er), 32'd1);
      check("range_rdata", rd, 32'h0);
      xact(0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat);
      check("last_word_err", 32'(er), 32'd0);
      xact(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      check("after_err_rdata", rd, 32'hDEADBEAA);
      xact(1, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      check("be0_err", 32'(er), 32'd0);
      xact(0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
      check("bp_rdata", rd, 32'hDEADBEAA);
      req_valid = 1; req_we = 0; req_addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      rst = 0;
      @(negedge clk);
      rst = 1;
      check("post_reset_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         check("dropped_rsp_valid", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      xact(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      check("post_reset_rdata", rd, 32'hDEADBEAA);
      check("post_reset_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         r = int'($urandom % 8);
         a = {24'h0, 4'($urandom), 2'b00};
         if (r == 6) a = a | 32'($urandom_range(1, 3));
         if (r == 7) a = 32'h400 + 32'($urandom % 4096);
         rst = ($urandom % 150) != 0;
         req_valid = $urandom % 2;
         req_we = $urandom % 2;
         req_addr = a;
         req_wdata = $urandom;
         req_be = 4'($urandom);
         rsp_ready = ($urandom % 3) != 0;
      end
      @(negedge clk);
      rst = 1; req_valid = 0; rsp_ready = 1;
      repeat (10) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
